// File: rtl/sdu_pkg.sv
// Shared SDU serial definitions: receiver/transmitter state encoding and oversampling constants.
package sdu_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_t;

  localparam int OVERSAMPLE = 16;
  localparam int MID        = 7;

  // Clocks per oversample tick, floored at 1 so slow-clock builds still run.
  function automatic int calc_div(input int clk_hz, input int baud);
    int d;
    d = clk_hz / (baud * OVERSAMPLE);
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/sdu_byte_fifo.sv
// First-word-fall-through byte FIFO; head byte reads as zero while empty.
module sdu_byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [7:0]               push_data,
  input  logic                     pop,
  output logic [7:0]               rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign count   = count_q;
  assign rd_data = empty ? 8'h00 : mem_q[rptr_q];

  // A pop frees a slot in the same cycle, so a push into a full FIFO still lands.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wptr_d  = do_push ? wptr_q + 1'b1 : wptr_q;
    rptr_d  = do_pop  ? rptr_q + 1'b1 : rptr_q;
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= push_data;
  end

endmodule

// File: rtl/sdu_uart_rx.sv
// SDU serial receive front end: 8N1 at 16x oversampling, false-start and framing rejection,
// received bytes buffered in a FWFT FIFO for the command parser.
module sdu_uart_rx
  import sdu_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rxd,
  input  logic                          rd_en,
  output logic [7:0]                    rd_data,
  output logic                          empty,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          busy,
  output logic                          frame_err,
  output logic                          overrun
);

  localparam int DIV = calc_div(CLK_HZ, BAUD);
  localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic            sync1_q, sync2_q, rxd_s;
  logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
  logic            tick;
  rx_state_t       state_q, state_d;
  logic [3:0]      s_q, s_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shreg_q, shreg_d;
  logic            frame_err_q, frame_err_d;
  logic            overrun_q, overrun_d;
  logic            push;

  assign rxd_s     = sync2_q;
  assign tick      = (tick_cnt_q == TW'(DIV - 1));
  assign busy      = (state_q != IDLE);
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

  always_comb begin
    tick_cnt_d  = tick ? '0 : TW'(tick_cnt_q + 1'b1);
    state_d     = state_q;
    s_d         = s_q;
    bit_d       = bit_q;
    shreg_d     = shreg_q;
    frame_err_d = 1'b0;
    push        = 1'b0;
    case (state_q)
      IDLE: if (!rxd_s) begin
        // Restart the divider so ticks line up with the start edge.
        state_d    = START;
        s_d        = '0;
        tick_cnt_d = '0;
      end
      START: if (tick) begin
        if (s_q == 4'(MID)) begin
          s_d     = '0;
          bit_d   = '0;
          state_d = rxd_s ? IDLE : DATA;
        end else begin
          s_d = s_q + 1'b1;
        end
      end
      DATA: if (tick) begin
        if (s_q == 4'(OVERSAMPLE - 1)) begin
          shreg_d = {rxd_s, shreg_q[7:1]};
          s_d     = '0;
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = STOP;
        end else begin
          s_d = s_q + 1'b1;
        end
      end
      STOP: if (tick) begin
        if (s_q == 4'(OVERSAMPLE - 1)) begin
          s_d = '0;
          if (rxd_s) begin
            push    = 1'b1;
            state_d = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = BREAK;
          end
        end else begin
          s_d = s_q + 1'b1;
        end
      end
      BREAK: if (rxd_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A concurrent pop makes room, so only a push against a full, unread FIFO is lost.
    overrun_d = push && full && !rd_en;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      tick_cnt_q  <= '0;
      state_q     <= IDLE;
      s_q         <= '0;
      bit_q       <= '0;
      shreg_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sync1_q     <= rxd;
      sync2_q     <= sync1_q;
      tick_cnt_q  <= tick_cnt_d;
      state_q     <= state_d;
      s_q         <= s_d;
      bit_q       <= bit_d;
      shreg_q     <= shreg_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  sdu_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (shreg_d),
    .pop       (rd_en),
    .rd_data   (rd_data),
    .empty     (empty),
    .full      (full),
    .count     (count)
  );

endmodule
